// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM state encoding and compare-result codes
// for the multi-cycle ALU (alu_mc) and its iterative divider.
package alu_pkg;

  // Opcode map
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_NAND = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_XNOR = 4'b1001;
  localparam logic [3:0] ALU_EQ   = 4'b1010;
  localparam logic [3:0] ALU_GT   = 4'b1011;
  localparam logic [3:0] ALU_LT   = 4'b1100;
  localparam logic [3:0] ALU_SHR  = 4'b1101;
  localparam logic [3:0] ALU_SHL  = 4'b1110;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  // Control FSM states
  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } alu_state_e;

  // Compare-op result codes
  localparam logic [1:0] CMP_EQ = 2'd1;
  localparam logic [1:0] CMP_GT = 2'd2;
  localparam logic [1:0] CMP_LT = 2'd3;

endpackage

// File: rtl/alu_div_seq.sv
// alu_div_seq: restoring shift-subtract divider, one quotient bit per
// clock, MSB first. Quotient/remainder outputs are the values produced by
// the current iteration so the owner can register them on the final edge
// (done=1). Only compiled into alu_mc when ALU_DIV_EN is defined.
module alu_div_seq #(
  parameter int A_width = 8,
  parameter int B_width = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [A_width-1:0] dividend_i,
  input  logic [B_width-1:0] divisor_i,
  output logic               done_o,
  output logic [A_width-1:0] quotient_o,
  output logic [B_width-1:0] remainder_o
);

  localparam int CNT_W = (A_width > 1) ? $clog2(A_width) : 1;

  logic [A_width-1:0] quo_q;
  logic [B_width-1:0] rem_q;
  logic [B_width-1:0] dvs_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               run_q;

  logic [B_width:0]   trial_s;
  logic [B_width:0]   diff_s;
  logic [B_width-1:0] rem_nx_s;
  logic               qbit_s;

  // One restoring step: shift in next dividend bit, subtract if it fits
  always_comb begin
    trial_s = {rem_q, quo_q[A_width-1]};
    diff_s  = trial_s - {1'b0, dvs_q};
    if (trial_s >= {1'b0, dvs_q}) begin
      qbit_s   = 1'b1;
      rem_nx_s = diff_s[B_width-1:0];
    end else begin
      qbit_s   = 1'b0;
      rem_nx_s = trial_s[B_width-1:0];
    end
  end

  assign quotient_o  = {quo_q[A_width-2:0], qbit_s};
  assign remainder_o = rem_nx_s;
  assign done_o      = run_q && (cnt_q == '0);

  // Divider datapath and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
      cnt_q <= CNT_W'(A_width - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      quo_q <= quotient_o;
      rem_q <= rem_nx_s;
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end else begin
      run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU. Single-cycle ops register their
// result one clock after acceptance; divide uses alu_div_seq and holds
// Busy while it iterates. Configuration macro: ALU_DIV_EN (defined =
// iterative divider present; undefined = divide returns 0 with Err=1).
module alu_mc
  import alu_pkg::*;
#(
  parameter int A_width   = 8,
  parameter int B_width   = 8,
  parameter int OUT_width = A_width + B_width
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 ALU_EN,
  input  logic [A_width-1:0]   A,
  input  logic [B_width-1:0]   B,
  input  logic [3:0]           ALU_FUN,
  output logic                 Busy,
  output logic [OUT_width-1:0] ALU_out,
  output logic                 Out_valid,
  output logic                 Err
);

  alu_state_e           state_q, state_d;
  logic [OUT_width-1:0] alu_out_q, alu_out_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic [OUT_width-1:0] a_ext_s, b_ext_s, op_res_s;

  // Operands are zero-extended before every operation
  assign a_ext_s = OUT_width'(A);
  assign b_ext_s = OUT_width'(B);

`ifdef ALU_DIV_EN
  logic                 div_start_s;
  logic                 div_done_s;
  logic [A_width-1:0]   div_quo_s;
  logic [B_width-1:0]   div_rem_s;

  alu_div_seq #(
    .A_width (A_width),
    .B_width (B_width)
  ) u_div (
    .clk         (CLK),
    .rst_n       (Reset),
    .start_i     (div_start_s),
    .dividend_i  (A),
    .divisor_i   (B),
    .done_o      (div_done_s),
    .quotient_o  (div_quo_s),
    .remainder_o (div_rem_s)
  );

  assign Busy = (state_q == DIV);
`else
  assign Busy = 1'b0;
`endif

  // Single-cycle operation results
  always_comb begin
    op_res_s = '0;
    case (ALU_FUN)
      ALU_ADD:  op_res_s = a_ext_s + b_ext_s;
      ALU_SUB:  op_res_s = a_ext_s - b_ext_s;
      ALU_MUL:  op_res_s = a_ext_s * b_ext_s;
      ALU_AND:  op_res_s = a_ext_s & b_ext_s;
      ALU_OR:   op_res_s = a_ext_s | b_ext_s;
      ALU_NAND: op_res_s = ~(a_ext_s & b_ext_s);
      ALU_NOR:  op_res_s = ~(a_ext_s | b_ext_s);
      ALU_XOR:  op_res_s = a_ext_s ^ b_ext_s;
      ALU_XNOR: op_res_s = ~(a_ext_s ^ b_ext_s);
      ALU_EQ:   op_res_s = (a_ext_s == b_ext_s) ? OUT_width'(CMP_EQ) : '0;
      ALU_GT:   op_res_s = (a_ext_s >  b_ext_s) ? OUT_width'(CMP_GT) : '0;
      ALU_LT:   op_res_s = (a_ext_s <  b_ext_s) ? OUT_width'(CMP_LT) : '0;
      ALU_SHR:  op_res_s = a_ext_s >> 1;
      ALU_SHL:  op_res_s = a_ext_s << 1;
      default:  op_res_s = '0;
    endcase
  end

  // Control FSM: request acceptance, divide sequencing, result capture
  always_comb begin
    state_d   = state_q;
    alu_out_d = alu_out_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
`ifdef ALU_DIV_EN
    div_start_s = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ALU_EN) begin
          if (ALU_FUN == ALU_DIV) begin
`ifdef ALU_DIV_EN
            if (B == '0) begin
              alu_out_d = '1;
              err_d     = 1'b1;
              valid_d   = 1'b1;
            end else begin
              div_start_s = 1'b1;
              state_d     = DIV;
            end
`else
            alu_out_d = '0;
            err_d     = 1'b1;
            valid_d   = 1'b1;
`endif
          end else begin
            alu_out_d = op_res_s;
            valid_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
`ifdef ALU_DIV_EN
      DIV: begin
        if (div_done_s) begin
          alu_out_d = OUT_width'({div_rem_s, div_quo_s});
          valid_d   = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = DIV;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      alu_out_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign ALU_out   = alu_out_q;
  assign Out_valid = valid_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (A_width = B_width = 8).
// Directed cases plus randomized ops compared against an arithmetic
// reference model. Divide expectations follow the ALU_DIV_EN setting.
module tb_alu_mc;

  localparam int AW = 8;
  localparam int BW = 8;
  localparam int OW = 16;
`ifdef ALU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          Reset = 1'b0;
  logic          ALU_EN = 1'b0;
  logic [AW-1:0] A = '0;
  logic [BW-1:0] B = '0;
  logic [3:0]    ALU_FUN = 4'd0;
  logic          Busy;
  logic [OW-1:0] ALU_out;
  logic          Out_valid;
  logic          Err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mc #(.A_width(AW), .B_width(BW), .OUT_width(OW)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .ALU_EN    (ALU_EN),
    .A         (A),
    .B         (B),
    .ALU_FUN   (ALU_FUN),
    .Busy      (Busy),
    .ALU_out   (ALU_out),
    .Out_valid (Out_valid),
    .Err       (Err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: returns {err, result[15:0]} from plain arithmetic
  function automatic logic [16:0] model(input int a, input int b, input int fun);
    int r;
    bit e;
    r = 0;
    e = 1'b0;
    case (fun)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a * b;
      3: begin
        if (!DIV_ON) begin
          r = 0;
          e = 1'b1;
        end else if (b == 0) begin
          r = 65535;
          e = 1'b1;
        end else begin
          r = (a % b) * 256 + (a / b);
        end
      end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = ~(a & b);
      7:  r = ~(a | b);
      8:  r = a ^ b;
      9:  r = ~(a ^ b);
      10: r = (a == b) ? 1 : 0;
      11: r = (a > b) ? 2 : 0;
      12: r = (a < b) ? 3 : 0;
      13: r = a / 2;
      14: r = a * 2;
      default: r = 0;
    endcase
    r = r & 65535;
    return {e, r[15:0]};
  endfunction

  // Issue one request and check result, latency, strobe width and hold
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun,
                       input bit poke);
    logic [16:0] exp;
    int n;
    bit done;
    exp = model(int'(a), int'(b), int'(fun));
    @(negedge CLK);
    A = a; B = b; ALU_FUN = fun; ALU_EN = 1'b1;
    @(negedge CLK);
    ALU_EN = 1'b0;
    if (DIV_ON && fun == 4'd3 && b != 8'd0) begin
      chk("div_busy_rise", 32'(Busy), 32'd1);
      chk("div_no_early_valid", 32'(Out_valid), 32'd0);
      n = 0;
      done = 1'b0;
      while (!done && n < 40) begin
        A = 8'($urandom);
        B = 8'($urandom);
        ALU_FUN = poke ? 4'd0 : 4'($urandom);
        ALU_EN = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge CLK);
        n++;
        if (Out_valid === 1'b1) done = 1'b1;
        else chk("div_busy_hold", 32'(Busy), 32'd1);
      end
      ALU_EN = 1'b0;
      chk("div_latency", 32'(n), 32'(AW));
      chk("div_busy_fall", 32'(Busy), 32'd0);
    end else begin
      chk("op_valid", 32'(Out_valid), 32'd1);
      chk("op_busy", 32'(Busy), 32'd0);
    end
    chk("op_result", 32'(ALU_out), 32'(exp[15:0]));
    chk("op_err", 32'(Err), 32'(exp[16]));
    @(negedge CLK);
    chk("strobe_drop", 32'(Out_valid), 32'd0);
    chk("err_drop", 32'(Err), 32'd0);
    chk("result_hold", 32'(ALU_out), 32'(exp[15:0]));
  endtask

  initial begin
    logic [16:0] exp;
    logic [3:0]  f;
    int          n;

    // Reset state
    #12;
    chk("rst_out", 32'(ALU_out), 32'd0);
    chk("rst_valid", 32'(Out_valid), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    @(negedge CLK);
    Reset = 1'b1;

    // Directed cases
    do_op(8'hFF, 8'h01, 4'd0, 1'b0);
    chk("add_ff_01", 32'(ALU_out), 32'h0100);
    do_op(8'd3, 8'd5, 4'd1, 1'b0);
    chk("sub_3_5", 32'(ALU_out), 32'hFFFE);
    do_op(8'h81, 8'h00, 4'd14, 1'b0);
    chk("shl_81", 32'(ALU_out), 32'h0102);
    do_op(8'd200, 8'd7, 4'd3, 1'b1);
    chk("div_200_7", 32'(ALU_out), DIV_ON ? 32'h041C : 32'h0000);
    do_op(8'd5, 8'd0, 4'd3, 1'b0);
    chk("div_by_zero", 32'(ALU_out), DIV_ON ? 32'hFFFF : 32'h0000);
    do_op(8'd9, 8'd3, 4'd3, 1'b0);
    do_op(8'h0F, 8'h33, 4'd6, 1'b0);
    do_op(8'd7, 8'd7, 4'd10, 1'b0);

    // Back-to-back single-cycle ops, one result per clock
    for (int i = 0; i < 6; i++) begin
      f = 4'($urandom_range(0, 15));
      if (f == 4'd3) f = 4'd15;
      A = 8'($urandom); B = 8'($urandom); ALU_FUN = f; ALU_EN = 1'b1;
      exp = model(int'(A), int'(B), int'(f));
      @(negedge CLK);
      chk("b2b_valid", 32'(Out_valid), 32'd1);
      chk("b2b_result", 32'(ALU_out), 32'(exp[15:0]));
    end
    ALU_EN = 1'b0;

    // Randomized ops, including divides with and without zero divisor
    for (int i = 0; i < 60; i++) begin
      f = 4'($urandom_range(0, 15));
      if (i % 5 == 0) f = 4'd3;
      do_op(8'($urandom), (i % 11 == 0) ? 8'd0 : 8'($urandom), f, 1'($urandom_range(0, 1)));
    end

    // Reset mid-operation aborts with no result
`ifdef ALU_DIV_EN
    @(negedge CLK);
    A = 8'd255; B = 8'd1; ALU_FUN = 4'd3; ALU_EN = 1'b1;
    @(negedge CLK);
    ALU_EN = 1'b0;
    repeat (2) @(negedge CLK);
    chk("pre_rst_busy", 32'(Busy), 32'd1);
`else
    @(negedge CLK);
    A = 8'd3; B = 8'd5; ALU_FUN = 4'd1; ALU_EN = 1'b1;
    @(negedge CLK);
    ALU_EN = 1'b0;
    chk("pre_rst_out", 32'(ALU_out), 32'hFFFE);
`endif
    Reset = 1'b0;
    #1;
    chk("mid_rst_out", 32'(ALU_out), 32'd0);
    chk("mid_rst_valid", 32'(Out_valid), 32'd0);
    chk("mid_rst_err", 32'(Err), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge CLK);
      if (Out_valid === 1'b1) n++;
    end
    chk("no_valid_after_abort", 32'(n), 32'd0);
    do_op(8'd1, 8'd1, 4'd0, 1'b0);
    chk("add_after_rst", 32'(ALU_out), 32'h0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU; next generation of the system's single-cycle registered ALU. Executes the same 16 opcodes on width-parametrised operands from the register-file/control FSM. Single-cycle ops complete in one clock. Division runs on an iterative restoring divider returning quotient and remainder. Adds a busy/accept handshake, a one-cycle result strobe and an error flag.

## Interface
- A_width, 8: operand A width, ≥2
- B_width, 8: operand B width, ≥2, ≤A_width
- OUT_width, A_width+B_width: result width
- CLK  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- ALU_EN  in  1  operation request; accepted on a rising edge when Busy=0
- A  in  A_width  operand A, unsigned
- B  in  B_width  operand B, unsigned
- ALU_FUN  in  4  opcode
- Busy  out  1  divider running; requests ignored
- ALU_out  out  OUT_width  result register; holds last result
- Out_valid  out  1  one-cycle strobe: ALU_out updated
- Err  out  1  valid with Out_valid: divide-by-zero or unsupported divide

## Operation
- Opcodes:
  - 0000 A+B
  - 0001 A−B, two's-complement wrap at OUT_width
  - 0010 A*B, full product
  - 0011 divide
  - 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR
  - 1010 A==B→1 else 0
  - 1011 A>B→2 else 0
  - 1100 A<B→3 else 0
  - 1101 A>>1
  - 1110 A<<1, zero fill, no bit loss
  - 1111→0
- Width rules:
  - Operands are zero-extended to OUT_width before every operation.
  - Bitwise ops therefore produce ones above A_width for NAND, NOR and XNOR.
- Divide result: ALU_out = {remainder[B_width-1:0], quotient[A_width-1:0]}.
- FSM states:
  - IDLE: accept requests.
    - Single-cycle op: register result, Out_valid=1, stay in IDLE.
    - 0011 with B≠0: latch A and B, clear partial remainder, counter=A_width−1, go to DIV.
    - 0011 with B=0: ALU_out=all ones, Err=1, Out_valid=1, stay in IDLE.
  - DIV: one quotient bit per clock, MSB first.
    - At counter=0, register the result, pulse Out_valid, return to IDLE.
- Busy = (state==DIV).
- ALU_EN while Busy: dropped with no side effects. No queueing.
- Between results: Out_valid=0 and Err=0; ALU_out holds its value.
- Operands and opcode may change freely while Busy; the latched copies are used.

## Timing
- Reset values: ALU_out=0, Out_valid=0, Err=0, Busy=0, state IDLE, counter 0.
- Reset asserted mid-divide aborts the divide immediately. No Out_valid is produced for the aborted divide.
- Single-cycle op accepted at edge e0: result and Out_valid visible after e0 (latency 1).
- Divide accepted at e0:
  - Busy=1 after e0.
  - Iterations occur on edges e1..e(A_width).
  - After e(A_width): result and Out_valid=1 visible, and Busy=0 in the same cycle (latency A_width+1).
- Back-to-back: a new request may be accepted on the edge right after Busy falls. Single-cycle ops give one result every clock.

## Configuration
- ALU_DIV_EN defined: iterative divider compiled in, behaviour as above.
- ALU_DIV_EN undefined:
  - No divider logic; Busy tied to 0 and the FSM reduces to IDLE only.
  - Opcode 0011 completes in one cycle with ALU_out=0, Err=1, Out_valid=1.

## Structure
- Package alu_pkg holds:
  - Opcode localparams (ALU_ADD … ALU_NOP)
  - State encoding typedef (IDLE, DIV)
  - Compare-result constants 1/2/3
- Sub-module alu_div_seq, inside ALU_DIV_EN:
  - Inputs: start, dividend, divisor.
  - Outputs: done, quotient, remainder.
  - Contains the restoring shift-subtract datapath and bit counter.
  - The top-level FSM owns the handshake.

## Test plan
(A_width = B_width = 8 throughout)
- Add: A=8'hFF, B=8'h01, FUN 0000 → next cycle ALU_out=16'h0100, Out_valid high exactly one cycle, Err=0.
- Subtract: A=3, B=5, FUN 0001 → ALU_out=16'hFFFE. Then FUN 1110 with A=8'h81 → 16'h0102.
- Divide: A=200, B=7, FUN 0011 → Busy high for 8 cycles, then ALU_out=16'h041C with Out_valid. An ADD request pulsed mid-divide is ignored and produces no extra Out_valid.
- Divide by zero: A=5, B=0, FUN 0011 → next cycle ALU_out=16'hFFFF, Err=1, Busy never rises.
- Reset mid-divide: assert Reset 3 cycles into 255/1 → all outputs 0 immediately. After release, an ADD 1+1 gives 16'h0002 in one cycle.
- Macro off (ALU_DIV_EN undefined): FUN 0011 with A=9, B=3 → next cycle ALU_out=0, Err=1, Busy=0.
